// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit for the 5-stage RV32 pipeline with a register
// scoreboard covering the variable-latency multi-cycle (MUL/DIV) unit.
// Forward, stall, flush and start outputs are combinational; sb_busy and
// stall_cycles are registered.
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_AW-1:0]    rs1D,
  input  logic [REG_AW-1:0]    rs2D,
  input  logic [REG_AW-1:0]    rdD,
  input  logic                 use_rs1D,
  input  logic                 use_rs2D,
  input  logic                 regwriteD,
  input  logic                 mcopD,
  input  logic [REG_AW-1:0]    rs1E,
  input  logic [REG_AW-1:0]    rs2E,
  input  logic [REG_AW-1:0]    rdE,
  input  logic                 loadE,
  input  logic                 mcopE,
  input  logic                 pcsrcE,
  input  logic [REG_AW-1:0]    rdM,
  input  logic [REG_AW-1:0]    rdW,
  input  logic                 regwriteM,
  input  logic                 regwriteW,
  input  logic                 mc_busy,
  input  logic                 mc_done,
  input  logic [REG_AW-1:0]    mc_rd,
  output logic [1:0]           forwardaE,
  output logic [1:0]           forwardbE,
  output logic                 stallF,
  output logic                 stallD,
  output logic                 flushD,
  output logic                 flushE,
  output logic                 mc_start,
  output logic [NUM_REGS-1:0]  sb_busy,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  localparam logic [1:0]           FWD_RF  = 2'b00;
  localparam logic [1:0]           FWD_W   = 2'b01;
  localparam logic [1:0]           FWD_M   = 2'b10;
  localparam logic [REG_AW-1:0]    REG_X0  = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                fwd_a;
  logic                fwd_b;
  logic [1:0]          fwd_sel_a;
  logic [1:0]          fwd_sel_b;
  logic                pend_rs1;
  logic                pend_rs2;
  logic                pend_rd;
  logic                lwstall;
  logic                sbstall;
  logic                mcstall;
  logic                anystall;
  logic                stall_int;
  logic [NUM_REGS-1:0] sb_next;

  // Select the newest in-flight producer of a source register; M beats W.
  function automatic logic [1:0] fwd_select(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rd_m,
    input logic              we_m,
    input logic [REG_AW-1:0] rd_w,
    input logic              we_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (we_m && (rd_m != REG_X0) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (we_w && (rd_w != REG_X0) && (rd_w == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

  // A register is pending while its multi-cycle result is outstanding,
  // including the op that is launching from E this cycle.
  function automatic logic is_pending(
    input logic [REG_AW-1:0]   r,
    input logic [NUM_REGS-1:0] busy,
    input logic                mcop_e,
    input logic [REG_AW-1:0]   rd_e
  );
    return (r != REG_X0) && (busy[r] || (mcop_e && (rd_e == r)));
  endfunction

  // Forward selects for both execute-stage operands.
  always_comb begin
    fwd_a     = 1'b0;
    fwd_b     = 1'b0;
    fwd_sel_a = fwd_select(rs1E, rdM, regwriteM, rdW, regwriteW);
    fwd_sel_b = fwd_select(rs2E, rdM, regwriteM, rdW, regwriteW);
    fwd_a     = (fwd_sel_a != FWD_RF);
    fwd_b     = (fwd_sel_b != FWD_RF);
  end

  // Pending lookups for the decode-stage operands and destination.
  always_comb begin
    pend_rs1 = is_pending(rs1D, sb_busy, mcopE, rdE);
    pend_rs2 = is_pending(rs2D, sb_busy, mcopE, rdE);
    pend_rd  = is_pending(rdD,  sb_busy, mcopE, rdE);
  end

  // Stall sources: load-use, scoreboard RAW/WAW, and structural.
  always_comb begin
    lwstall  = loadE && (rdE != REG_X0) &&
               ((use_rs1D && (rs1D == rdE)) || (use_rs2D && (rs2D == rdE)));
    sbstall  = (use_rs1D && pend_rs1) || (use_rs2D && pend_rs2) ||
               (regwriteD && pend_rd);
    // The unit is free next cycle when it completes now, so D may advance.
    mcstall  = mcopD && (mcopE || (mc_busy && !mc_done));
    anystall = lwstall || sbstall || mcstall;
    // A taken redirect must always load the PC, so it overrides stalls.
    stall_int = anystall && !pcsrcE;
  end

  // Pipeline control outputs, forced to a flushing, non-stalling state in reset.
  always_comb begin
    forwardaE = FWD_RF;
    forwardbE = FWD_RF;
    stallF    = 1'b0;
    stallD    = 1'b0;
    flushD    = 1'b1;
    flushE    = 1'b1;
    mc_start  = 1'b0;
    if (!rst) begin
      forwardaE = fwd_a ? fwd_sel_a : FWD_RF;
      forwardbE = fwd_b ? fwd_sel_b : FWD_RF;
      stallF    = stall_int;
      stallD    = stall_int;
      flushD    = pcsrcE;
      flushE    = pcsrcE || anystall;
      mc_start  = mcopE;
    end
  end

  // Next scoreboard: completion clears first, a launch then sets (set wins).
  always_comb begin
    sb_next = sb_busy;
    if (mc_done) begin
      sb_next[mc_rd] = 1'b0;
    end
    if (mcopE && (rdE != REG_X0)) begin
      sb_next[rdE] = 1'b1;
    end
    sb_next[0] = 1'b0;
  end

  // Scoreboard register; reset aborts all outstanding multi-cycle ops.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_busy <= '0;
    end else begin
      sb_busy <= sb_next;
    end
  end

  // Saturating count of cycles in which decode was held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stallD && (stall_cycles != CNT_MAX)) begin
      stall_cycles <= stall_cycles + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_hazard_scoreboard;

  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1D, rs2D, rdD, rs1E, rs2E, rdE, rdM, rdW, mc_rd;
  logic        use_rs1D, use_rs2D, regwriteD, mcopD, loadE, mcopE, pcsrcE;
  logic        regwriteM, regwriteW, mc_busy, mc_done;
  logic [1:0]  forwardaE, forwardbE;
  logic        stallF, stallD, flushD, flushE, mc_start;
  logic [31:0] sb_busy;
  logic [CW-1:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit [31:0] m_sb;
  int        m_cnt;

  hazard_scoreboard #(.NUM_REGS(32), .REG_AW(5), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
    .use_rs1D(use_rs1D), .use_rs2D(use_rs2D), .regwriteD(regwriteD), .mcopD(mcopD),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .loadE(loadE), .mcopE(mcopE), .pcsrcE(pcsrcE),
    .rdM(rdM), .rdW(rdW), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .mc_busy(mc_busy), .mc_done(mc_done), .mc_rd(mc_rd),
    .forwardaE(forwardaE), .forwardbE(forwardbE),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .mc_start(mc_start), .sb_busy(sb_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int fwd_model(int rs);
    if (regwriteM && rdM != 0 && rdM == rs) return 2;
    if (regwriteW && rdW != 0 && rdW == rs) return 1;
    return 0;
  endfunction

  function automatic bit pend_model(int r);
    return (r != 0) && (m_sb[r] || (mcopE && rdE == r));
  endfunction

  task automatic idle_inputs();
    rst = 0; rs1D = 0; rs2D = 0; rdD = 0; use_rs1D = 0; use_rs2D = 0;
    regwriteD = 0; mcopD = 0; rs1E = 0; rs2E = 0; rdE = 0; loadE = 0;
    mcopE = 0; pcsrcE = 0; rdM = 0; rdW = 0; regwriteM = 0; regwriteW = 0;
    mc_busy = 0; mc_done = 0; mc_rd = 0;
  endtask

  // Called just after a negedge with inputs set: checks every output against
  // the model, then advances the model across the next posedge.
  task automatic step();
    bit lw, sb, mc, any, st;
    int ea, eb;
    #1;
    lw  = loadE && rdE != 0 && ((use_rs1D && rs1D == rdE) || (use_rs2D && rs2D == rdE));
    sb  = (use_rs1D && pend_model(int'(rs1D))) || (use_rs2D && pend_model(int'(rs2D))) ||
          (regwriteD && pend_model(int'(rdD)));
    mc  = mcopD && (mcopE || (mc_busy && !mc_done));
    any = lw || sb || mc;
    st  = rst ? 1'b0 : (any && !pcsrcE);
    ea  = rst ? 0 : fwd_model(int'(rs1E));
    eb  = rst ? 0 : fwd_model(int'(rs2E));
    check("fwdA",   32'(forwardaE), 32'(ea));
    check("fwdB",   32'(forwardbE), 32'(eb));
    check("stallF", 32'(stallF), 32'(st));
    check("stallD", 32'(stallD), 32'(st));
    check("flushD", 32'(flushD), 32'(rst ? 1'b1 : pcsrcE));
    check("flushE", 32'(flushE), 32'(rst ? 1'b1 : (pcsrcE || any)));
    check("mcstart", 32'(mc_start), 32'(rst ? 1'b0 : mcopE));
    check("sb_busy", sb_busy, m_sb);
    check("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
    @(posedge clk);
    if (rst) begin
      m_sb  = '0;
      m_cnt = 0;
    end else begin
      if (mc_done) m_sb[mc_rd] = 1'b0;
      if (mcopE && rdE != 0) m_sb[rdE] = 1'b1;
      m_sb[0] = 1'b0;
      if (st && m_cnt < CMAX) m_cnt++;
    end
    @(negedge clk);
  endtask

  initial begin
    m_sb = '0; m_cnt = 0;
    idle_inputs();
    rst = 1;
    @(negedge clk);
    step();
    step();

    // 1: preload the scoreboard, then reset clears it
    rst = 0; mcopE = 1; rdE = 3;
    step();
    mcopE = 0; rdE = 0;
    check("preload", sb_busy[3], 32'd1);
    rst = 1;
    step();
    #1;
    check("rst_flushD", 32'(flushD), 32'd1);
    check("rst_stallF", 32'(stallF), 32'd0);
    step();
    check("rst_sb", sb_busy, 32'd0);
    check("rst_cnt", 32'(stall_cycles), 32'd0);

    // 2: forwarding priority
    idle_inputs();
    rs1E = 5; rdM = 5; rdW = 5; regwriteM = 1; regwriteW = 1;
    #1 check("fwd_m", 32'(forwardaE), 32'd2);
    step();
    regwriteM = 0;
    #1 check("fwd_w", 32'(forwardaE), 32'd1);
    step();
    rs2E = 0; rdW = 0; regwriteW = 1;
    #1 check("fwd_x0", 32'(forwardbE), 32'd0);
    step();

    // 3: load-use stall for one cycle
    idle_inputs();
    loadE = 1; rdE = 6; rs2D = 6; use_rs2D = 1;
    #1 check("lw_stallD", 32'(stallD), 32'd1);
    check("lw_flushE", 32'(flushE), 32'd1);
    step();
    idle_inputs();
    #1 check("lw_cnt", 32'(stall_cycles), 32'd1);
    check("lw_release", 32'(stallD), 32'd0);
    step();

    // 4: multi-cycle RAW
    mcopE = 1; rdE = 7;
    #1 check("mc_start", 32'(mc_start), 32'd1);
    step();
    idle_inputs();
    mc_busy = 1; use_rs1D = 1; rs1D = 7;
    #1 check("sb7_set", sb_busy[7], 32'd1);
    check("raw_stall", 32'(stallD), 32'd1);
    step();
    step();
    mc_done = 1; mc_rd = 7;
    #1 check("raw_done_cycle", 32'(stallD), 32'd1);
    step();
    mc_done = 0; mc_busy = 0;
    #1 check("raw_release", 32'(stallD), 32'd0);
    check("sb7_clr", sb_busy[7], 32'd0);
    step();

    // 5: structural stall and branch priority
    idle_inputs();
    mcopD = 1; mc_busy = 1;
    #1 check("struct_stall", 32'(stallD), 32'd1);
    step();
    mc_done = 1;
    #1 check("struct_done", 32'(stallD), 32'd0);
    step();
    mc_done = 0; pcsrcE = 1;
    #1 check("br_stallF", 32'(stallF), 32'd0);
    check("br_flushD", 32'(flushD), 32'd1);
    check("br_flushE", 32'(flushE), 32'd1);
    step();

    // 6: counter saturation under a held scoreboard stall
    idle_inputs();
    rst = 1;
    step();
    rst = 0; mcopE = 1; rdE = 9;
    step();
    idle_inputs();
    use_rs1D = 1; rs1D = 9;
    for (int i = 0; i < 20; i++) step();
    check("sat15", 32'(stall_cycles), 32'd15);
    step();
    check("sat_hold", 32'(stall_cycles), 32'd15);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) < 3);
      rs1D      = 5'($urandom_range(0, 7));
      rs2D      = 5'($urandom_range(0, 7));
      rdD       = 5'($urandom_range(0, 7));
      use_rs1D  = 1'($urandom);
      use_rs2D  = 1'($urandom);
      regwriteD = 1'($urandom);
      mcopD     = ($urandom_range(0, 3) == 0);
      rs1E      = 5'($urandom_range(0, 7));
      rs2E      = 5'($urandom_range(0, 7));
      rdE       = 5'($urandom_range(0, 7));
      loadE     = ($urandom_range(0, 3) == 0);
      mcopE     = ($urandom_range(0, 4) == 0);
      pcsrcE    = ($urandom_range(0, 9) == 0);
      rdM       = 5'($urandom_range(0, 7));
      rdW       = 5'($urandom_range(0, 7));
      regwriteM = 1'($urandom);
      regwriteW = 1'($urandom);
      mc_busy   = 1'($urandom);
      mc_done   = ($urandom_range(0, 2) == 0);
      mc_rd     = 5'($urandom_range(0, 7));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Hazard and forwarding unit for the 5-stage RV32 pipeline, extended with a register scoreboard for a variable-latency multi-cycle execute unit (MUL/DIV). The unit writes through a second register-file write port.
Generates EX forwarding selects, load-use and scoreboard stalls, branch flushes, the multi-cycle start pulse and a saturating stall-cycle counter.
Sits beside the F/D/E/M/W pipeline registers and drives their stall and flush inputs.

Parameters:
NUM_REGS, 32, number of architectural registers; x0 is never tracked.
REG_AW, 5, register address width, equal to log2(NUM_REGS).
CNT_WIDTH, 16, width of the stall-cycle performance counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rs1D, rs2D, rdD  in  REG_AW  decode-stage register addresses
use_rs1D, use_rs2D  in  1  the decode instruction actually reads rs1 / rs2
regwriteD  in  1  the decode instruction writes rd
mcopD  in  1  the decode instruction is a multi-cycle op
rs1E, rs2E, rdE  in  REG_AW  execute-stage register addresses
loadE  in  1  execute instruction is a load (resultsrcE[0])
mcopE  in  1  execute instruction is a multi-cycle op
pcsrcE  in  1  branch/jump taken in execute
rdM, rdW  in  REG_AW  memory- and writeback-stage destinations
regwriteM, regwriteW  in  1  memory- and writeback-stage write enables
mc_busy  in  1  multi-cycle unit occupied
mc_done  in  1  one-cycle completion pulse; the result is written this cycle
mc_rd  in  REG_AW  destination of the completing multi-cycle op
forwardaE, forwardbE  out  2  00 = register file, 01 = resultW, 10 = aluresultM
stallF, stallD, flushD, flushE  out  1  pipeline control
mc_start  out  1  launch the multi-cycle op currently in E
sb_busy  out  NUM_REGS  scoreboard vector (registered)
stall_cycles  out  CNT_WIDTH  saturating count of stalled cycles (registered)

Behaviour:
- Clocking and reset: all state changes on the posedge of clk. rst is synchronous and active-high.
- Reset values: sb_busy=0 and stall_cycles=0.
- While rst is high, outputs are forced: flushD=flushE=1, stallF=stallD=0, mc_start=0, forward selects=00. mc_done is ignored.
- Forwarding (combinational):
  - forwardaE=10 if regwriteM & rdM!=0 & rdM==rs1E.
  - Otherwise 01 if regwriteW & rdW!=0 & rdW==rs1E.
  - Otherwise 00.
  - M takes priority over W. forwardbE uses the same rule with rs2E.
- Pending predicate (combinational): pend(r) = r!=0 & (sb_busy[r] | (mcopE & rdE==r)).
  - The current-cycle mc_done does not clear pend; the register is readable from the cycle after mc_done.
- Load-use stall: lwstall = loadE & rdE!=0 & ((use_rs1D & rs1D==rdE) | (use_rs2D & rs2D==rdE)).
- Scoreboard stall: sbstall = (use_rs1D & pend(rs1D)) | (use_rs2D & pend(rs2D)) | (regwriteD & pend(rdD)).
  - The rdD term blocks WAW hazards.
- Structural stall: mcstall = mcopD & (mcopE | (mc_busy & !mc_done)).
  - An mc op in D may advance in the same cycle as mc_done, because the unit is idle on the next cycle.
- Stall and flush outputs:
  - anystall = lwstall | sbstall | mcstall.
  - stallF = stallD = anystall & !pcsrcE. A redirect always loads the PC.
  - flushD = pcsrcE.
  - flushE = pcsrcE | anystall.
- mc_start = mcopE, exactly one cycle per op. The structural rule guarantees the unit is idle when mc_start is asserted.
- Scoreboard update (each cycle, when not in reset):
  - If mc_done, clear bit mc_rd.
  - Then, if mcopE & rdE!=0, set bit rdE. Set wins on the same index.
  - Bit 0 is always 0.
- stall_cycles increments on every cycle with stallD=1 and holds at 2^CNT_WIDTH-1.
- Reset mid-operation: the scoreboard clears at once. The multi-cycle unit shares rst and is aborted.
- Latency: stall, flush and forward outputs are combinational, with zero cycles from inputs. sb_busy and stall_cycles update one cycle after their cause.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with sb_busy preloaded nonzero -> sb_busy=0, stall_cycles=0, flushD=flushE=1, stallF=0, mc_start=0.
2. Forwarding: rs1E=5, rdM=rdW=5, both regwrite=1 -> forwardaE=10; regwriteM=0 -> 01; rs2E=0 with rdW=0 -> forwardbE=00.
3. Load-use: loadE=1, rdE=6, rs2D=6, use_rs2D=1 -> stallF=stallD=flushE=1 for one cycle, and stall_cycles increments by 1.
4. Multi-cycle RAW:
   - mcopE=1, rdE=7 -> mc_start=1, and sb_busy[7]=1 next cycle.
   - Decode with rs1D=7 stalls until mc_done=1 with mc_rd=7.
   - The decode stall is released on the following cycle.
5. Structural and branch priority:
   - mcopD=1 with mc_busy=1, mc_done=0 -> stallD=1; with mc_done=1 in the same cycle -> stallD=0.
   - Assert pcsrcE during any stall -> stallF=stallD=0, flushD=flushE=1.
6. Counter saturation: with CNT_WIDTH=4, hold a scoreboard stall for 20 cycles -> stall_cycles=15 and holds there.
